ff_sync_param: RTL

//   Parametrised single-clock FIFO. It is the ff_slave-side implementation behind the generic FIFO interface.

---
 rtl/ff_pkg.sv | 33 +++
 rtl/ff_mem_2p.sv | 34 +++
 rtl/ff_sync_param.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ff_pkg.sv
// Shared types and helpers for the parametrised single-clock FIFO.
package ff_pkg;

   // Registered status bundle; sticky flags live alongside the level flags
   typedef struct packed {
      logic full;
      logic empty;
      logic afull;
      logic aempty;
      logic ovrflw;
      logic undrflw;
   } ff_status_t;

   // Status value after reset or flush: empty, below both thresholds, no sticky events
   localparam ff_status_t FF_STATUS_RST = '{
      full:    1'b0,
      empty:   1'b1,
      afull:   1'b0,
      aempty:  1'b1,
      ovrflw:  1'b0,
      undrflw: 1'b0
   };

   // Pointer width: one extra bit over the address so full and empty are distinguishable
   function automatic int unsigned ff_ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic ff_is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/ff_mem_2p.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module ff_mem_2p #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_ir,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   // Next array contents: only the addressed entry changes on a write
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Storage register, no reset
   always_ff @(posedge clk_ir) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ff_sync_param.sv
// Parametrised single-clock FIFO with registered-read or FWFT output,
// fill level, almost-full/almost-empty thresholds, synchronous flush and
// sticky overflow/underflow flags.
module ff_sync_param
   import ff_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int FWFT      = 0,
   parameter int AFULL_TH  = 12,
   parameter int AEMPTY_TH = 4
) (
   input  logic                    clk_ir,
   input  logic                    rst_il,
   input  logic                    ff_flush,
   input  logic                    ff_wr_en,
   input  logic [DATA_W-1:0]       ff_wr_data,
   input  logic                    ff_rd_en,
   output logic [DATA_W-1:0]       ff_rd_data,
   output logic                    ff_full,
   output logic                    ff_empty,
   output logic                    ff_afull,
   output logic                    ff_aempty,
   output logic [$clog2(DEPTH):0]  ff_count,
   output logic                    ff_ovrflw,
   output logic                    ff_undrflw
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ff_ptr_w(DEPTH);

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_TH);
   localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_TH);

   // Elaboration-time parameter checks
   if (!ff_is_pow2(DEPTH) || (DEPTH < 4)) begin : g_chk_depth
      $error("ff_sync_param: DEPTH (%0d) must be a power of 2 and >= 4", DEPTH);
   end
   if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_chk_afull
      $error("ff_sync_param: AFULL_TH (%0d) must be in 1..DEPTH", AFULL_TH);
   end
   if ((AEMPTY_TH < 0) || (AEMPTY_TH >= DEPTH)) begin : g_chk_aempty
      $error("ff_sync_param: AEMPTY_TH (%0d) must be in 0..DEPTH-1", AEMPTY_TH);
   end

   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [PTR_W-1:0]  count_q, count_d;
   ff_status_t        status_q, status_d;
   logic              wr_acc;
   logic              rd_acc;
   logic [DATA_W-1:0] mem_rd_data;

   // Accept decisions use pre-cycle status; a flush cancels both requests
   always_comb begin
      wr_acc = ff_wr_en & ~status_q.full  & ~ff_flush;
      rd_acc = ff_rd_en & ~status_q.empty & ~ff_flush;
   end

   // Pointer and occupancy next-state; count is the modular pointer difference
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (ff_flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wr_acc) begin
            wptr_d = wptr_q + PTR_ONE;
         end
         if (rd_acc) begin
            rptr_d = rptr_q + PTR_ONE;
         end
      end
      count_d = wptr_d - rptr_d;
   end

   // Status flags registered from next-state count; sticky flags accumulate rejected requests
   always_comb begin
      status_d = FF_STATUS_RST;
      if (!ff_flush) begin
         status_d.full    = (count_d == DEPTH_C);
         status_d.empty   = (count_d == '0);
         status_d.afull   = (count_d >= AFULL_C);
         status_d.aempty  = (count_d <= AEMPTY_C);
         status_d.ovrflw  = status_q.ovrflw  | (ff_wr_en & status_q.full);
         status_d.undrflw = status_q.undrflw | (ff_rd_en & status_q.empty);
      end
   end

   // Pointer, count and status registers
   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         status_q <= FF_STATUS_RST;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         status_q <= status_d;
      end
   end

   ff_mem_2p #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk_ir  (clk_ir),
      .wr_en   (wr_acc),
      .wr_addr (wptr_q[ADDR_W-1:0]),
      .wr_data (ff_wr_data),
      .rd_addr (rptr_q[ADDR_W-1:0]),
      .rd_data (mem_rd_data)
   );

   if (FWFT == 0) begin : g_reg_rd
      logic [DATA_W-1:0] rd_data_q, rd_data_d;

      // Capture the head word only on an accepted read; hold otherwise
      always_comb begin
         rd_data_d = rd_data_q;
         if (rd_acc) begin
            rd_data_d = mem_rd_data;
         end
      end

      // Registered read data
      always_ff @(posedge clk_ir or negedge rst_il) begin
         if (!rst_il) begin
            rd_data_q <= '0;
         end else begin
            rd_data_q <= rd_data_d;
         end
      end

      assign ff_rd_data = rd_data_q;
   end else begin : g_fwft
      assign ff_rd_data = mem_rd_data;
   end

   assign ff_count   = count_q;
   assign ff_full    = status_q.full;
   assign ff_empty   = status_q.empty;
   assign ff_afull   = status_q.afull;
   assign ff_aempty  = status_q.aempty;
   assign ff_ovrflw  = status_q.ovrflw;
   assign ff_undrflw = status_q.undrflw;

endmodule
